// File: rtl/fetch_inst_buffer_pkg.sv
// Shared frontend definitions for the fetch instruction buffer: widths,
// the stored entry type and a popcount helper.
package fetch_inst_buffer_pkg;

  localparam int FETCH_WIDTH       = 4;
  localparam int FTB_PREDICT_WIDTH = 16;

  // Widest mask the popcount helper accepts; callers zero-extend to it.
  localparam int POPCNT_W = 32;

  // One predecoded instruction as handed from the fetcher to decode.
  typedef struct packed {
    logic        has_except;
    logic [15:0] insn;
  } fetchEntry_t;

  // Number of set bits in v.
  function automatic logic [5:0] count_one(input logic [POPCNT_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < POPCNT_W; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_buf_ptr.sv
// Wrap-bit circular pointer: index in the low bits, wrap flag on top.
// Advances by a variable amount and clears to zero on flush.
module fetch_buf_ptr #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic [AW:0]   n,
  output logic [AW:0]   ptr,
  output logic [AW:0]   ptr_next,
  output logic [AW-1:0] idx,
  output logic          wrap
);

  // Next pointer value: clear wins over advance.
  always_comb begin
    ptr_next = ptr;
    if (clr) begin
      ptr_next = '0;
    end else if (adv) begin
      ptr_next = ptr + n;
    end
  end

  // Pointer register, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

  assign idx  = ptr[AW-1:0];
  assign wrap = ptr[AW];

endmodule

// File: rtl/fetch_inst_buffer.sv
// Decoupling queue between the fetcher's compacted predecode output and
// the decode interface. Takes up to IN_WIDTH entries per cycle, offers up
// to OUT_WIDTH, and stops at the first excepting entry so it leaves alone.
//
// Handshake: the producer may present a contiguous i_enq_vld mask at any
// time, but it is only accepted on a cycle where the registered o_enq_rdy
// is 1 and i_flush is 0; otherwise it is dropped and must be held. The
// consumer takes every entry flagged in o_deq_vld on each cycle where
// i_deq_stall and i_flush are both 0; with stall high nothing is taken.
module fetch_inst_buffer
  import fetch_inst_buffer_pkg::*;
#(
  parameter  int  IN_WIDTH  = FTB_PREDICT_WIDTH / 2,
  parameter  int  OUT_WIDTH = FETCH_WIDTH,
  parameter  int  DEPTH     = 16,
  parameter  type ENTRY_T   = fetchEntry_t,
  localparam int  AW        = $clog2(DEPTH),
  localparam int  CW        = AW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic [IN_WIDTH-1:0]          i_enq_vld,
  input  ENTRY_T [IN_WIDTH-1:0]        i_enq_entry,
  output logic                         o_enq_rdy,
  input  logic                         i_deq_stall,
  output logic [OUT_WIDTH-1:0]         o_deq_vld,
  output ENTRY_T [OUT_WIDTH-1:0]       o_deq_entry,
  output logic [CW-1:0]                o_count
);

  ENTRY_T mem [DEPTH];

  logic [AW:0]          head, head_next, tail, tail_next;
  logic [AW-1:0]        head_idx, tail_idx;
  logic                 head_wrap, tail_wrap;
  logic [CW-1:0]        count, count_next, enq_n, deq_n;
  logic                 enq_fire, deq_adv, enq_rdy;
  logic [OUT_WIDTH-1:0] win, deq_vld;
  logic                 fence_found;
  int                   fence_pos;

  assign count    = tail - head;
  assign enq_fire = (|i_enq_vld) && enq_rdy && !i_flush;
  assign deq_adv  = !i_deq_stall && !i_flush;
  assign enq_n    = CW'(count_one(POPCNT_W'(i_enq_vld)));
  assign deq_n    = CW'(count_one(POPCNT_W'(deq_vld)));

  fetch_buf_ptr #(.DEPTH(DEPTH)) u_head (
    .clk      (clk),
    .rst      (rst),
    .clr      (i_flush),
    .adv      (deq_adv),
    .n        (deq_n),
    .ptr      (head),
    .ptr_next (head_next),
    .idx      (head_idx),
    .wrap     (head_wrap)
  );

  fetch_buf_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk      (clk),
    .rst      (rst),
    .clr      (i_flush),
    .adv      (enq_fire),
    .n        (enq_n),
    .ptr      (tail),
    .ptr_next (tail_next),
    .idx      (tail_idx),
    .wrap     (tail_wrap)
  );

  assign count_next = tail_next - head_next;

  // Write accepted entries in program order starting at the tail slot.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (i_enq_vld[i]) begin
          mem[tail_idx + AW'(i)] <= i_enq_entry[i];
        end
      end
    end
  end

  // Dequeue window: occupied slots starting at head, read straight from storage.
  always_comb begin
    win         = '0;
    o_deq_entry = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      win[k]         = CW'(k) < count;
      o_deq_entry[k] = mem[head_idx + AW'(k)];
    end
  end

  // Locate the oldest excepting entry inside the window.
  always_comb begin
    fence_found = 1'b0;
    fence_pos   = 0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      if (!fence_found && win[k] && o_deq_entry[k].has_except) begin
        fence_found = 1'b1;
        fence_pos   = k;
      end
    end
  end

  // Valid mask: stop before an excepting entry, or send it alone at the head.
  always_comb begin
    deq_vld = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      if (i_flush) begin
        deq_vld[k] = 1'b0;
      end else if (fence_found) begin
        deq_vld[k] = (fence_pos == 0) ? (k == 0) : (k < fence_pos);
      end else begin
        deq_vld[k] = win[k];
      end
    end
  end

  // Ready is registered from next-state occupancy so it holds a whole cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enq_rdy <= 1'b1;
    end else begin
      enq_rdy <= (CW'(DEPTH) - count_next) >= CW'(IN_WIDTH);
    end
  end

  assign o_enq_rdy = enq_rdy;
  assign o_deq_vld = deq_vld;
  assign o_count   = count;

  // The producer must present a mask packed toward bit 0.
  a_contig_mask : assert property (@(posedge clk) disable iff (!rst)
    (i_enq_vld & (i_enq_vld + IN_WIDTH'(1))) == '0);

  // Full occupancy and the pointer-based full condition must agree.
  a_full_ptrs : assert property (@(posedge clk) disable iff (!rst)
    (count == CW'(DEPTH)) == ((head_idx == tail_idx) && (head_wrap != tail_wrap)));

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    count <= CW'(DEPTH));

endmodule
